// File: rtl/wash_phase_timer_pkg.sv
// Shared definitions for the washing-machine controller and its phase timer.
// Provides state codes, clock-rate select encodings and default phase durations.
package wash_phase_timer_pkg;

  // Controller state codes, as driven on cur_state
  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_FILLING   = 3'b001,
    ST_WASHING   = 3'b011,
    ST_RINSING   = 3'b111,
    ST_SPINNING  = 3'b110
  } wm_state_e;

  // Clock-rate select: cycles per second = CLK_FREQ_1 << clk_freq
  localparam logic [1:0] CLK_SEL_X1 = 2'b00;
  localparam logic [1:0] CLK_SEL_X2 = 2'b01;
  localparam logic [1:0] CLK_SEL_X4 = 2'b10;
  localparam logic [1:0] CLK_SEL_X8 = 2'b11;

  // Default parameter values
  localparam int unsigned DEF_CLK_FREQ_1 = 1_000_000;
  localparam int unsigned DEF_FILL_SEC   = 120;
  localparam int unsigned DEF_WASH_SEC   = 300;
  localparam int unsigned DEF_RINSE_SEC  = 120;
  localparam int unsigned DEF_SPIN_SEC   = 60;
  localparam int unsigned DEF_SEC_W      = 9;

endpackage

// File: rtl/wm_tick_prescaler.sv
// Divides clk down to a one-second wrap indication.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr_i       synchronous clear of the prescaler (highest priority)
//   hold_i      freeze the prescaler, suppress the tick
//   clk_freq_i  rate select, terminal count = CLK_FREQ_1 << clk_freq_i
//   tick_c      combinational: prescaler wraps on the coming edge
module wm_tick_prescaler
  import wash_phase_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_1 = DEF_CLK_FREQ_1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       hold_i,
  input  logic [1:0] clk_freq_i,
  output logic       tick_c
);

  localparam int unsigned PW = $clog2(8 * CLK_FREQ_1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic [PW-1:0] tc_m1;
  logic          wrap;

  // Terminal count minus one for the selected rate
  always_comb begin
    tc_m1 = PW'((CLK_FREQ_1 << clk_freq_i) - 1);
  end

  // >= keeps the divider bounded if the rate is lowered mid-second
  assign wrap = (presc_q >= tc_m1);

  // Next-state: clear beats hold, hold beats the wrap
  always_comb begin
    presc_d = presc_q;
    tick_c  = 1'b0;
    if (clr_i) begin
      presc_d = '0;
    end else if (!hold_i) begin
      if (wrap) begin
        presc_d = '0;
        tick_c  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/wash_phase_timer.sv
// Per-phase duration timer for the washing-machine controller.
// Counts seconds in the current phase and flags when the phase duration elapses.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   cur_state     controller state code (selects the phase duration)
//   cnt_run       1 = count, 0 = clear timer on the next edge
//   cnt_stop      1 = freeze counting (spin pause)
//   clk_freq      rate select, cycles per second = CLK_FREQ_1 << clk_freq
//   state_finish  registered level: phase duration elapsed
//   sec_tick      registered one-cycle pulse per counted second
//   sec_left      combinational: seconds remaining in the phase
module wash_phase_timer
  import wash_phase_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_1 = DEF_CLK_FREQ_1,
  parameter int unsigned FILL_SEC   = DEF_FILL_SEC,
  parameter int unsigned WASH_SEC   = DEF_WASH_SEC,
  parameter int unsigned RINSE_SEC  = DEF_RINSE_SEC,
  parameter int unsigned SPIN_SEC   = DEF_SPIN_SEC,
  parameter int unsigned SEC_W      = DEF_SEC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       cur_state,
  input  logic             cnt_run,
  input  logic             cnt_stop,
  input  logic [1:0]       clk_freq,
  output logic             state_finish,
  output logic             sec_tick,
  output logic [SEC_W-1:0] sec_left
);

  logic [SEC_W-1:0] dur;
  logic [SEC_W-1:0] elapsed_q;
  logic [SEC_W-1:0] elapsed_d;
  logic             finish_q;
  logic             finish_d;
  logic             tick_q;
  logic             tick_d;
  logic             wrap_c;
  logic             last_sec;

  // Counting freezes while stopped or once the phase has finished
  wm_tick_prescaler #(
    .CLK_FREQ_1 (CLK_FREQ_1)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (!cnt_run),
    .hold_i     (cnt_stop || finish_q),
    .clk_freq_i (clk_freq),
    .tick_c     (wrap_c)
  );

  // Phase duration decode; idle and unused codes never finish
  always_comb begin
    dur = '0;
    case (cur_state)
      ST_FILLING:  dur = SEC_W'(FILL_SEC);
      ST_WASHING:  dur = SEC_W'(WASH_SEC);
      ST_RINSING:  dur = SEC_W'(RINSE_SEC);
      ST_SPINNING: dur = SEC_W'(SPIN_SEC);
      default:     dur = '0;
    endcase
  end

  // Extra bit so an elapsed counter at all-ones cannot alias a zero duration
  assign last_sec = (dur != '0) &&
                    (({1'b0, elapsed_q} + (SEC_W+1)'(1)) == {1'b0, dur});

  // Elapsed counter, finish flag and tick pulse
  always_comb begin
    elapsed_d = elapsed_q;
    finish_d  = finish_q;
    tick_d    = 1'b0;
    if (!cnt_run) begin
      elapsed_d = '0;
      finish_d  = 1'b0;
    end else if (wrap_c) begin
      elapsed_d = elapsed_q + SEC_W'(1);
      tick_d    = 1'b1;
      if (last_sec) begin
        finish_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elapsed_q <= '0;
      finish_q  <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      elapsed_q <= elapsed_d;
      finish_q  <= finish_d;
      tick_q    <= tick_d;
    end
  end

  assign state_finish = finish_q;
  assign sec_tick     = tick_q;

  // Remaining time, clamped when the duration drops below elapsed mid-phase
  assign sec_left = (dur > elapsed_q) ? (dur - elapsed_q) : '0;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer with a per-cycle reference model.
module tb_wash_phase_timer;
  import wash_phase_timer_pkg::*;

  localparam int unsigned CF = 4;
  localparam int unsigned FS = 3;
  localparam int unsigned WS = 5;
  localparam int unsigned RS = 3;
  localparam int unsigned SS = 2;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [2:0]    cur_state = 3'b000;
  logic          cnt_run = 1'b0;
  logic          cnt_stop = 1'b0;
  logic [1:0]    clk_freq = 2'b00;
  logic          state_finish;
  logic          sec_tick;
  logic [SW-1:0] sec_left;

  int checks = 0;
  int errors = 0;

  wash_phase_timer #(
    .CLK_FREQ_1 (CF),
    .FILL_SEC   (FS),
    .WASH_SEC   (WS),
    .RINSE_SEC  (RS),
    .SPIN_SEC   (SS),
    .SEC_W      (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cur_state    (cur_state),
    .cnt_run      (cnt_run),
    .cnt_stop     (cnt_stop),
    .clk_freq     (clk_freq),
    .state_finish (state_finish),
    .sec_tick     (sec_tick),
    .sec_left     (sec_left)
  );

  always #5 clk = ~clk;

  function automatic int dur_of(logic [2:0] s);
    case (s)
      3'b001:  return FS;
      3'b011:  return WS;
      3'b111:  return RS;
      3'b110:  return SS;
      default: return 0;
    endcase
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycles counted into the current second, seconds counted in phase
  int m_sub = 0;
  int m_sec = 0;
  bit m_fin = 1'b0;
  bit m_tick = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sub  <= 0;
      m_sec  <= 0;
      m_fin  <= 1'b0;
      m_tick <= 1'b0;
    end else begin
      m_tick <= 1'b0;
      if (!cnt_run) begin
        m_sub <= 0;
        m_sec <= 0;
        m_fin <= 1'b0;
      end else if (!cnt_stop && !m_fin) begin
        if (m_sub + 1 >= int'(CF << clk_freq)) begin
          m_sub  <= 0;
          m_sec  <= (m_sec + 1) % (1 << SW);
          m_tick <= 1'b1;
          if (dur_of(cur_state) != 0 && ((m_sec + 1) % (1 << SW)) == dur_of(cur_state))
            m_fin <= 1'b1;
        end else begin
          m_sub <= m_sub + 1;
        end
      end
    end
  end

  function automatic int exp_left();
    int d;
    d = dur_of(cur_state);
    return (d > m_sec) ? d - m_sec : 0;
  endfunction

  // Every cycle, away from the active edge
  always @(negedge clk) begin
    chk("mdl_finish", state_finish, m_fin);
    chk("mdl_tick", sec_tick, m_tick);
    chk("mdl_sec_left", sec_left, exp_left());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fin(output int n, input int budget);
    n = 0;
    do begin
      step();
      n++;
    end while (!state_finish && n < budget);
    if (!state_finish) chk("finish_timeout", state_finish, 1);
  endtask

  int n;
  wm_state_e ph [6] = '{ST_FILLING, ST_WASHING, ST_RINSING, ST_WASHING, ST_RINSING, ST_SPINNING};
  int ph_len [6] = '{12, 20, 12, 20, 12, 8};

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    #1;
    chk("rst_finish", state_finish, 0);
    chk("rst_tick", sec_tick, 0);
    chk("rst_sec_left", sec_left, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // 1: Fill at x1, tick every 4 cycles, finish after 12
    cur_state = ST_FILLING;
    #1;
    chk("t1_left_start", sec_left, 3);
    cnt_run = 1'b1;
    repeat (4) step();
    chk("t1_tick4", sec_tick, 1);
    chk("t1_left4", sec_left, 2);
    repeat (4) step();
    chk("t1_left8", sec_left, 1);
    chk("t1_fin8", state_finish, 0);
    repeat (3) step();
    chk("t1_fin11", state_finish, 0);
    step();
    chk("t1_fin12", state_finish, 1);
    chk("t1_left12", sec_left, 0);
    repeat (3) step();
    chk("t1_fin_held", state_finish, 1);
    cnt_run = 1'b0;
    step();
    chk("t1_cleared", state_finish, 0);

    // 2: Fill at x8, finish after 96
    clk_freq = CLK_SEL_X8;
    cnt_run = 1'b1;
    wait_fin(n, 200);
    chk("t2_latency", n, 96);
    cnt_run = 1'b0;
    step();

    // 2b: drop rate mid-second, wrap on the very next edge
    cnt_run = 1'b1;
    repeat (10) step();
    chk("t2b_no_tick", sec_tick, 0);
    clk_freq = CLK_SEL_X1;
    step();
    chk("t2b_tick", sec_tick, 1);
    chk("t2b_left", sec_left, 2);
    cnt_run = 1'b0;
    step();

    // 3: Spin with a 10-cycle stop at elapsed=1
    cur_state = ST_SPINNING;
    cnt_run = 1'b1;
    repeat (4) step();
    chk("t3_left1", sec_left, 1);
    cnt_stop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_stop_tick", sec_tick, 0);
    end
    cnt_stop = 1'b0;
    wait_fin(n, 50);
    chk("t3_total", 14 + n, 18);

    // 4: Rinse finish, then clear into Wash
    cnt_run = 1'b0;
    cur_state = ST_RINSING;
    step();
    cnt_run = 1'b1;
    wait_fin(n, 50);
    chk("t4_rinse", n, 12);
    cnt_run = 1'b0;
    cur_state = ST_WASHING;
    step();
    chk("t4_fin_clr", state_finish, 0);
    chk("t4_left", sec_left, 5);
    cnt_run = 1'b1;
    wait_fin(n, 50);
    chk("t4_wash", n, 20);

    // 5: Idle never finishes
    cnt_run = 1'b0;
    cur_state = ST_IDLE;
    step();
    cnt_run = 1'b1;
    repeat (100) step();
    chk("t5_idle_fin", state_finish, 0);
    chk("t5_idle_left", sec_left, 0);

    // 5b: async reset mid-Wash, right as a tick is showing
    cnt_run = 1'b0;
    cur_state = ST_WASHING;
    step();
    cnt_run = 1'b1;
    repeat (8) step();
    chk("t5_pre_tick", sec_tick, 1);
    chk("t5_pre_left", sec_left, 3);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tick", sec_tick, 0);
    chk("t5_rst_fin", state_finish, 0);
    chk("t5_rst_left_wash", sec_left, 5);
    cur_state = ST_IDLE;
    #1;
    chk("t5_rst_left_idle", sec_left, 0);
    repeat (3) step();
    rst_n = 1'b1;
    cnt_run = 1'b0;
    step();

    // 6: full cycle with double wash
    cur_state = ph[0];
    for (int i = 0; i < 6; i++) begin
      cnt_run = 1'b1;
      wait_fin(n, 100);
      chk($sformatf("t6_phase%0d", i), n, ph_len[i]);
      cnt_run = 1'b0;
      cur_state = (i < 5) ? ph[i+1] : ST_IDLE;
      step();
    end
    repeat (3) step();
    chk("t6_end_fin", state_finish, 0);
    chk("t6_end_left", sec_left, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
